// File: rtl/baccarat_ctrl.sv
// rtl/baccarat_ctrl.sv - Baccarat round sequencer: deals six cards, applies third-card rules, lights winner.
// Optional macro BACCARAT_CTRL_STATE_DBG_EN adds the state_dbg output (state index, IDLE=0 .. DONE=9).
module baccarat_ctrl #(
  parameter int NATURAL_MIN  = 8,
  parameter int PLAYER_STAND = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef BACCARAT_CTRL_STATE_DBG_EN
  ,
  output logic [3:0] state_dbg
`endif
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEAL_P1 = 4'd1,
    DEAL_D1 = 4'd2,
    DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4,
    EVAL1   = 4'd5,
    DEAL_P3 = 4'd6,
    EVAL2   = 4'd7,
    DEAL_D3 = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic [3:0] NAT_MIN   = NATURAL_MIN[3:0];
  localparam logic [3:0] STAND_MIN = PLAYER_STAND[3:0];

  state_t     state;
  state_t     state_next;
  logic [3:0] p3val;
  logic       banker_draw;

  always_ff @(posedge slow_clock) begin
    if (!resetb) state <= IDLE;
    else         state <= state_next;
  end

  // Face cards and tens count zero; pcard3 = 0 (no card) also counts zero.
  assign p3val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  always_comb begin
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (p3val != 4'd8);
      4'd4:             banker_draw = (p3val >= 4'd2) && (p3val <= 4'd7);
      4'd5:             banker_draw = (p3val >= 4'd4) && (p3val <= 4'd7);
      4'd6:             banker_draw = (p3val >= 4'd6) && (p3val <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = DEAL_P1;
      DEAL_P1: state_next = DEAL_D1;
      DEAL_D1: state_next = DEAL_P2;
      DEAL_P2: state_next = DEAL_D2;
      DEAL_D2: state_next = EVAL1;
      EVAL1: begin
        if ((pscore >= NAT_MIN) || (dscore >= NAT_MIN)) state_next = DONE;
        else if (pscore < STAND_MIN)                    state_next = DEAL_P3;
        else if (dscore <= 4'd5)                        state_next = DEAL_D3;
        else                                            state_next = DONE;
      end
      DEAL_P3: state_next = EVAL2;
      EVAL2:   state_next = banker_draw ? DEAL_D3 : DONE;
      DEAL_D3: state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_pcard1      = (state == DEAL_P1);
    load_dcard1      = (state == DEAL_D1);
    load_pcard2      = (state == DEAL_P2);
    load_dcard2      = (state == DEAL_D2);
    load_pcard3      = (state == DEAL_P3);
    load_dcard3      = (state == DEAL_D3);
    player_win_light = (state == DONE) && (pscore >= dscore);
    dealer_win_light = (state == DONE) && (dscore >= pscore);
  end

`ifdef BACCARAT_CTRL_STATE_DBG_EN
  assign state_dbg = state;
`endif

endmodule

// File: tb/tb_baccarat_ctrl.sv
// tb/tb_baccarat_ctrl.sv - Self-checking bench for baccarat_ctrl against a rule-level round model.
module tb_baccarat_ctrl;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [3:0] pcard3, pscore, dscore;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
`ifdef BACCARAT_CTRL_STATE_DBG_EN
  logic [3:0] state_dbg;
`endif

  int checks = 0;
  int errors = 0;

  baccarat_ctrl dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pcard3           (pcard3),
    .pscore           (pscore),
    .dscore           (dscore),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
`ifdef BACCARAT_CTRL_STATE_DBG_EN
    ,
    .state_dbg        (state_dbg)
`endif
  );

  always #5 slow_clock = ~slow_clock;

  // Banker rule: dealer on 4/5/6 draws when the player's third card is in [2*d-6, 7].
  function automatic bit banker(input int d, input int p3);
    int v;
    v = (p3 >= 10) ? 0 : p3;
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d <= 6) return (v >= 2 * d - 6) && (v <= 7);
    return 1'b0;
  endfunction

  // Expected {P1,D1,P2,D2,P3,D3,pwin,dwin} for cycle c of a round whose scores are
  // (ps1,ds1) through cycle 6 and (ps2,ds2) from cycle 7 on.
  function automatic logic [7:0] model(input int c, input int ps1, input int ds1,
                                       input int pc3, input int ps2, input int ds2);
    bit nat, pd, dd;
    int done_c, ps, ds;
    logic [7:0] v;
    nat = (ps1 >= 8) || (ds1 >= 8);
    pd  = !nat && (ps1 < 6);
    dd  = !nat && (pd ? banker(ds2, pc3) : (ds1 <= 5));
    done_c = 6 + (pd ? 2 : 0) + (dd ? 1 : 0);
    ps = (c <= 6) ? ps1 : ps2;
    ds = (c <= 6) ? ds1 : ds2;
    v = 8'h00;
    if (c >= 1 && c <= 4) v[8 - c] = 1'b1;
    if (pd && c == 6) v[3] = 1'b1;
    if (dd && c == (pd ? 8 : 6)) v[2] = 1'b1;
    if (c >= done_c) begin
      v[1] = (ps >= ds);
      v[0] = (ds >= ps);
    end
    return v;
  endfunction

  function automatic logic [7:0] observed();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
            load_pcard3, load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reset, then run one round for 31 cycles; pcard3 is scrambled while DONE must hold.
  task automatic run_round(input string tag, input int ps1, input int ds1,
                           input int pc3, input int ps2, input int ds2);
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = 4'(ps1);
    dscore = 4'(ds1);
    pcard3 = 4'(pc3);
    @(negedge slow_clock);
    resetb = 1'b1;
    check({tag, " c0"}, observed(), 8'h00);
`ifdef BACCARAT_CTRL_STATE_DBG_EN
    checks++;
    assert (state_dbg === 4'd0)
    else begin
      errors++;
      $error("FAIL %s state_dbg observed=%0d expected=0", tag, state_dbg);
    end
`endif
    for (int c = 1; c <= 30; c++) begin
      @(negedge slow_clock);
      check($sformatf("%s c%0d", tag, c), observed(), model(c, ps1, ds1, pc3, ps2, ds2));
      if (c == 6) begin
        pscore = 4'(ps2);
        dscore = 4'(ds2);
      end
      if (c >= 10) pcard3 = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    resetb = 1'b0;
    pcard3 = '0;
    pscore = '0;
    dscore = '0;

    // Mid-round reset during DEAL_D2 (cycle 4).
    @(negedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
    repeat (4) @(negedge slow_clock);
    check("mid d2_strobe", observed(), 8'b0001_0000);
    resetb = 1'b0;
    @(negedge slow_clock);
    check("mid reset_idle", observed(), 8'h00);

    run_round("natural",      8, 3, 0, 8, 3);
    run_round("pdraw_dstand", 4, 7, 9, 3, 7);
    run_round("bank6_p6",     2, 6, 6, 2, 6);
    run_round("bank6_p7",     2, 6, 7, 2, 6);
    run_round("bank6_p5",     2, 6, 5, 2, 6);
    run_round("bank6_pQ",     2, 6, 12, 2, 6);
    run_round("bank3_p8",     2, 3, 8, 2, 3);
    run_round("pstand_ddraw", 7, 5, 0, 7, 7);
    run_round("both_stand",   6, 6, 0, 6, 6);
    run_round("oor_natural",  3, 12, 0, 3, 12);

    for (int r = 0; r < 40; r++) begin
      int a, b, k, x, y;
      a = $urandom_range(0, 15);
      b = (r % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      k = $urandom_range(0, 13);
      x = $urandom_range(0, 9);
      y = $urandom_range(0, 9);
      run_round($sformatf("rand%0d", r), a, b, k, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
